// File: rtl/elastic_fork_demux.sv
// Eager-fork demultiplexer: one valid/ready stream fanned out to a masked subset
// of consumers through a 2-entry buffer; a token retires once every selected port took it.
module elastic_fork_demux #(
  parameter int NUM_OUTPUTS = 2,
  parameter int DATA_WIDTH  = 32
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic [NUM_OUTPUTS-1:0]            mask_i,
  input  logic [DATA_WIDTH-1:0]             data_i,
  input  logic                              valid_i,
  output logic                              ready_o,
  output logic [NUM_OUTPUTS*DATA_WIDTH-1:0] data_o,
  output logic [NUM_OUTPUTS-1:0]            valid_o,
  input  logic [NUM_OUTPUTS-1:0]            ready_i
);

  logic [DATA_WIDTH-1:0]  r_head;
  logic [DATA_WIDTH-1:0]  r_tail;
  logic [1:0]             r_count;
  logic [NUM_OUTPUTS-1:0] r_sent;

  logic                   w_not_empty;
  logic                   w_push;
  logic                   w_pop;
  logic [NUM_OUTPUTS-1:0] w_done;
  logic [NUM_OUTPUTS-1:0] w_hs;
  logic [DATA_WIDTH-1:0]  w_head_out;

  logic [DATA_WIDTH-1:0]  w_head_nxt;
  logic [DATA_WIDTH-1:0]  w_tail_nxt;
  logic [1:0]             w_count_nxt;
  logic [NUM_OUTPUTS-1:0] w_sent_nxt;

  // ready_o depends only on the occupancy register, so upstream never sees ready_i
  assign w_not_empty = (r_count != 2'd0);
  assign ready_o     = (r_count != 2'd2);
  assign w_push      = valid_i & ready_o;
  assign valid_o     = {NUM_OUTPUTS{w_not_empty}} & mask_i & ~r_sent;
  assign w_hs        = valid_o & ready_i;
  assign w_done      = ~mask_i | r_sent | ready_i;
  assign w_pop       = w_not_empty & (&w_done);
  assign w_head_out  = w_not_empty ? r_head : {DATA_WIDTH{1'b0}};

  genvar gi;
  generate
    for (gi = 0; gi < NUM_OUTPUTS; gi++) begin : g_out
      assign data_o[gi*DATA_WIDTH +: DATA_WIDTH] = w_head_out;
    end
  endgenerate

  // Next-state for buffer, occupancy and per-port delivery tracking
  always_comb begin
    w_head_nxt  = r_head;
    w_tail_nxt  = r_tail;
    w_count_nxt = r_count;
    w_sent_nxt  = r_sent;
    if (w_pop) begin
      w_sent_nxt = {NUM_OUTPUTS{1'b0}};
      if (w_push) begin
        // only reachable with one entry: the incoming token becomes the new head
        w_head_nxt = data_i;
      end else begin
        w_head_nxt  = r_tail;
        w_count_nxt = r_count - 2'd1;
      end
    end else begin
      w_sent_nxt = r_sent | w_hs;
      if (w_push) begin
        if (r_count == 2'd0) begin
          w_head_nxt = data_i;
        end else begin
          w_tail_nxt = data_i;
        end
        w_count_nxt = r_count + 2'd1;
      end else begin
        w_count_nxt = r_count;
      end
    end
  end

  // State registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_head  <= {DATA_WIDTH{1'b0}};
      r_tail  <= {DATA_WIDTH{1'b0}};
      r_count <= 2'd0;
      r_sent  <= {NUM_OUTPUTS{1'b0}};
    end else begin
      r_head  <= w_head_nxt;
      r_tail  <= w_tail_nxt;
      r_count <= w_count_nxt;
      r_sent  <= w_sent_nxt;
    end
  end

endmodule

// File: tb/tb_elastic_fork_demux.sv
// Directed bench for elastic_fork_demux with NUM_OUTPUTS=2, DATA_WIDTH=32.
module tb_elastic_fork_demux;

  localparam int N  = 2;
  localparam int DW = 32;

  logic          clk_i;
  logic          rst_ni;
  logic [N-1:0]  mask_i;
  logic [DW-1:0] data_i;
  logic          valid_i;
  logic          ready_o;
  logic [N*DW-1:0] data_o;
  logic [N-1:0]  valid_o;
  logic [N-1:0]  ready_i;

  int total;
  int bad;

  elastic_fork_demux #(.NUM_OUTPUTS(N), .DATA_WIDTH(DW)) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .mask_i (mask_i),
    .data_i (data_i),
    .valid_i(valid_i),
    .ready_o(ready_o),
    .data_o (data_o),
    .valid_o(valid_o),
    .ready_i(ready_i)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Move to the next negedge and let combinational outputs settle after input changes
  task automatic step();
    @(negedge clk_i);
  endtask

  function automatic logic [63:0] both(input logic [31:0] v);
    both = {v, v};
  endfunction

  initial begin
    total   = 0;
    bad     = 0;
    rst_ni  = 1'b0;
    mask_i  = 2'b11;
    data_i  = 32'hA5;
    valid_i = 1'b1;
    ready_i = 2'b00;

    // Reset held with valid_i asserted
    step(); #1;
    check("rst_valid", valid_o, 2'b00);
    check("rst_data", data_o, 64'h0);
    check("rst_ready", ready_o, 1'b1);
    step(); #1;
    check("rst_valid2", valid_o, 2'b00);
    rst_ni = 1'b1;
    step(); valid_i = 1'b0; #1;
    check("a5_valid", valid_o, 2'b11);
    check("a5_data", data_o, both(32'hA5));
    ready_i = 2'b11;
    step(); #1;
    check("a5_retired", valid_o, 2'b00);
    check("a5_ready", ready_o, 1'b1);

    // Full-rate broadcast stream
    for (int k = 1; k <= 8; k++) begin
      step();
      data_i  = k;
      valid_i = 1'b1;
      #1;
      check("strm_ready", ready_o, 1'b1);
      if (k == 1) check("strm_valid0", valid_o, 2'b00);
      else begin
        check("strm_valid", valid_o, 2'b11);
        check("strm_data", data_o, both(k - 1));
      end
    end
    step(); valid_i = 1'b0; #1;
    check("strm_last_valid", valid_o, 2'b11);
    check("strm_last_data", data_o, both(32'h8));
    step(); #1;
    check("strm_empty", valid_o, 2'b00);

    // Eager fork: port0 takes first, port1 later
    ready_i = 2'b00;
    data_i = 32'h11; valid_i = 1'b1;
    step(); data_i = 32'h22; ready_i = 2'b01; #1;
    check("fork_c1_valid", valid_o, 2'b11);
    check("fork_c1_data", data_o, both(32'h11));
    step(); valid_i = 1'b0; #1;
    check("fork_c2_valid", valid_o, 2'b10);
    check("fork_c2_ready", ready_o, 1'b0);
    step(); #1;
    check("fork_c3_valid", valid_o, 2'b10);
    step(); ready_i = 2'b10; #1;
    check("fork_c4_valid", valid_o, 2'b10);
    check("fork_c4_data", data_o, both(32'h11));
    step(); ready_i = 2'b00; #1;
    check("fork_next_valid", valid_o, 2'b11);
    check("fork_next_data", data_o, both(32'h22));
    check("fork_next_ready", ready_o, 1'b1);
    ready_i = 2'b11;
    step(); #1;
    check("fork_drained", valid_o, 2'b00);

    // Backpressure on a single selected port
    mask_i = 2'b01; ready_i = 2'b00;
    data_i = 32'h31; valid_i = 1'b1; #1;
    check("bp_ready0", ready_o, 1'b1);
    step(); data_i = 32'h32; #1;
    check("bp_ready1", ready_o, 1'b1);
    check("bp_valid1", valid_o, 2'b01);
    step(); data_i = 32'h33; #1;
    check("bp_full", ready_o, 1'b0);
    step(); #1;
    check("bp_full2", ready_o, 1'b0);
    check("bp_head", data_o, both(32'h31));
    ready_i = 2'b01;
    step(); #1;
    check("bp_ready_back", ready_o, 1'b1);
    check("bp_second", data_o, both(32'h32));
    step(); valid_i = 1'b0; #1;
    check("bp_third", data_o, both(32'h33));
    check("bp_third_valid", valid_o, 2'b01);
    step(); #1;
    check("bp_empty", valid_o, 2'b00);
    check("bp_empty_ready", ready_o, 1'b1);

    // All-zero mask discards tokens at full rate
    mask_i = 2'b00; ready_i = 2'b00;
    data_i = 32'h5; valid_i = 1'b1; #1;
    check("z_ready0", ready_o, 1'b1);
    step(); data_i = 32'h6; #1;
    check("z_valid1", valid_o, 2'b00);
    check("z_ready1", ready_o, 1'b1);
    step(); valid_i = 1'b0; #1;
    check("z_valid2", valid_o, 2'b00);
    check("z_data2", data_o, both(32'h6));
    check("z_ready2", ready_o, 1'b1);
    step(); #1;
    check("z_empty_data", data_o, 64'h0);

    // Reset while full with a partially delivered head
    mask_i = 2'b11; ready_i = 2'b00;
    data_i = 32'h41; valid_i = 1'b1;
    step(); data_i = 32'h42;
    step(); valid_i = 1'b0; ready_i = 2'b01; #1;
    check("mr_full", ready_o, 1'b0);
    step(); ready_i = 2'b00; #1;
    check("mr_sent0", valid_o, 2'b10);
    rst_ni = 1'b0; #1;
    check("mr_rst_valid", valid_o, 2'b00);
    check("mr_rst_ready", ready_o, 1'b1);
    check("mr_rst_data", data_o, 64'h0);
    step(); rst_ni = 1'b1; #1;
    check("mr_post_valid", valid_o, 2'b00);
    data_i = 32'h77; valid_i = 1'b1;
    step(); valid_i = 1'b0; #1;
    check("mr_77_valid", valid_o, 2'b11);
    check("mr_77_data", data_o, both(32'h77));
    ready_i = 2'b11;
    step(); #1;
    check("mr_77_done", valid_o, 2'b00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/elastic_fork_demux.md
Name: elastic_fork_demux

Overview:
- Distribution-side counterpart of the CGRA PE input multiplexer: takes one elastic (valid/ready) data stream and delivers each token to a configurable subset of NUM_OUTPUTS consumers.
- Uses an eager fork: each selected consumer may accept the token in a different cycle, and the token retires only when all selected consumers have taken it.
- A 2-entry input buffer registers the path and decouples upstream ready from downstream ready.
- Sits between a PE/FU result and the interconnect fan-out.

Parameters:
- NUM_OUTPUTS, 2, number of consumer ports (>=1).
- DATA_WIDTH, 32, token width in bits.

Ports:
- clk_i  input  1  clock.
- rst_ni  input  1  asynchronous active-low reset.
- mask_i  input  NUM_OUTPUTS  configuration. Bit i=1 routes tokens to output i. Quasi-static: changed only while the block is empty.
- data_i  input  DATA_WIDTH  upstream token.
- valid_i  input  1  upstream token valid.
- ready_o  output  1  block can accept a token.
- data_o  output  NUM_OUTPUTS*DATA_WIDTH  flattened outputs. Slice i = [(i+1)*DATA_WIDTH-1 : i*DATA_WIDTH]. Every slice carries the head token.
- valid_o  output  NUM_OUTPUTS  per-output token valid.
- ready_i  input  NUM_OUTPUTS  per-output consumer ready.

Behaviour:
- State: 2-entry buffer (head, tail), occupancy count 0..2, per-output sent[NUM_OUTPUTS] register.
- Reset (async assert, rst_ni=0):
  - count=0, sent=0, buffer data=0.
  - valid_o=0, data_o=0, ready_o=1.
  - Reset mid-token discards buffered tokens and sent state immediately.
- Push: valid_i & ready_o. ready_o = (count<2), derived only from registers with no combinational path from ready_i.
- Latency: token pushed in cycle t appears on valid_o/data_o in cycle t+1 when the buffer was empty. Zero-bubble throughput of 1 token/cycle when all selected ready_i=1.
- valid_o[i] = (count>0) & mask_i[i] & ~sent[i].
- Output handshake on port i: valid_o[i] & ready_i[i].
- done[i] = ~mask_i[i] | sent[i] | ready_i[i].
- Pop (head retires): count>0 & AND of all done[i].
  - On pop, sent is cleared to 0.
  - Otherwise sent[i] is set for every port handshaking this cycle.
  - Once sent[i]=1, valid_o[i] stays 0 for the rest of that token.
- Ordering: FIFO. After a pop, the tail becomes the head.
- Simultaneous push and pop:
  - count=1: count stays 1; the new token becomes head in the next cycle.
  - count=2: push is blocked by ready_o=0.
- mask_i all zero: every token is discarded. Pop fires whenever count>0, all valid_o stay 0, throughput is 1 token/cycle.
- Single selected output: behaves as a plain 2-entry elastic buffer on that port.
- valid_o[i] & data_o slice i stay stable until handshake or pop. data_o slices of unselected or idle ports are undefined-but-stable (head value, or 0 when empty).
- Backpressure: with count=2 and no pop, ready_o=0 until the head retires.

Test Plan:
- Reset with valid_i=1 held, then release: valid_o=0, data_o=0, ready_o=1 during reset. First token 0xA5 appears on the selected outputs one cycle after its push.
- NUM_OUTPUTS=2, mask=2'b11, all ready_i=1, stream 0x1..0x8: every token appears on both ports, one per cycle, in order, with no bubbles. ready_o stays 1.
- mask=2'b11, ready_i=2'b01 for 3 cycles then 2'b10:
  - Port0 takes 0x11 once, then valid_o[0]=0.
  - Port1 takes 0x11 in the 4th cycle; the token retires then.
  - Next token 0x22 presented to both ports.
- Backpressure: mask=2'b01, ready_i=0, push 3 tokens. Two are accepted, then ready_o=0. After ready_i[0]=1 the tokens drain in order and ready_o returns to 1.
- mask=2'b00, push 0x5,0x6: valid_o stays 0, both tokens drain in consecutive cycles, ready_o never drops.
- Reset asserted with count=2 and sent[0]=1: after release count=0, sent=0, valid_o=0. A new token 0x77 is delivered to all selected ports.
